// File: rtl/reg_hex_streamer.sv
// Walks the register file and streams each value as an 11-glyph text line
// ("R", index, space, 8 hex digits) over valid/ready. Optional macro
// REG_HEX_BLANK_ZEROS_EN blanks leading zero digits (last digit always shown).
module reg_hex_streamer #(
  parameter int NUM_REGS     = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic [8:0]  addr,
  input  logic [31:0] register_value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_code,
  output logic [2:0]  char_row,
  output logic [3:0]  char_col,
  output logic        finished_register
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  localparam logic [2:0] LAST_REG  = 3'(NUM_REGS - 1);
  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);
  localparam logic [7:0] GLYPH_R     = 8'd52;
  localparam logic [7:0] GLYPH_SPACE = 8'd53;

  state_t      state, state_n;
  logic [2:0]  reg_idx, reg_idx_n;
  logic [3:0]  col, col_n;
  logic [1:0]  wait_cnt, wait_cnt_n;
  logic [31:0] value, value_n;
  logic [7:0]  code_n;

  // Glyph for a given column of a line; digit columns 3..10 walk the
  // captured value from the most-significant nibble down.
  function automatic logic [7:0] glyph(input logic [3:0] c, input logic [2:0] r,
                                       input logic [31:0] v);
    logic [2:0]  k;
    logic [31:0] top;
    logic [7:0]  g;
    k   = 3'(c - 4'd3);
    top = v >> (5'd28 - {k, 2'b00});
    g   = {4'd0, top[3:0]};
`ifdef REG_HEX_BLANK_ZEROS_EN
    if (top == 32'd0 && c != 4'd10) g = GLYPH_SPACE;
`endif
    case (c)
      4'd0:    g = GLYPH_R;
      4'd1:    g = {5'd0, r};
      4'd2:    g = GLYPH_SPACE;
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    state_n    = state;
    reg_idx_n  = reg_idx;
    col_n      = col;
    wait_cnt_n = wait_cnt;
    value_n    = value;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          reg_idx_n  = 3'd0;
          col_n      = 4'd0;
          wait_cnt_n = 2'd0;
        end
      end
      FETCH: begin
        if (wait_cnt == LAST_WAIT) begin
          value_n    = register_value;
          wait_cnt_n = 2'd0;
          col_n      = 4'd0;
          state_n    = EMIT;
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end
      EMIT: begin
        if (char_ready) begin
          if (col == 4'd10) begin
            col_n = 4'd0;
            if (reg_idx == LAST_REG) begin
              state_n = DONE;
            end else begin
              reg_idx_n = reg_idx + 3'd1;
              state_n   = FETCH;
            end
          end else begin
            col_n = col + 4'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Code is precomputed from next-state values so char_code is a flop.
    code_n = (state_n == EMIT) ? glyph(col_n, reg_idx_n, value_n) : 8'd0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      reg_idx           <= 3'd0;
      col               <= 4'd0;
      wait_cnt          <= 2'd0;
      value             <= 32'd0;
      busy              <= 1'b0;
      char_valid        <= 1'b0;
      char_code         <= 8'd0;
      finished_register <= 1'b0;
    end else begin
      state             <= state_n;
      reg_idx           <= reg_idx_n;
      col               <= col_n;
      wait_cnt          <= wait_cnt_n;
      value             <= value_n;
      busy              <= (state_n != IDLE);
      char_valid        <= (state_n == EMIT);
      char_code         <= code_n;
      finished_register <= (state_n == DONE);
    end
  end

  assign addr     = {6'd0, reg_idx};
  assign char_row = reg_idx;
  assign char_col = col;

endmodule
